// File: rtl/conv_enc_pkg.sv
// Shared types and the single-bit step of the rate-1/2, K=3 convolutional
// encoder (generators X=7, Y=5 octal).
package conv_enc_pkg;

   localparam int unsigned K   = 3;
   localparam logic [2:0]  G_X = 3'b111;
   localparam logic [2:0]  G_Y = 3'b101;

   typedef logic [K-1:0] enc_state_t;

   typedef enum logic [1:0] {IDLE, ENCODE, HOLD} fsm_t;

   // Returns {next_state, X, Y}; taps apply to the state after shifting the bit in.
   function automatic logic [K+1:0] enc_step(input enc_state_t state, input logic b);
      enc_state_t ns;
      ns = {state[K-2:0], b};
      return {ns, ^(ns & G_X), ^(ns & G_Y)};
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder slice: chains BITS_PER_CYCLE encoder steps in one cycle,
// lowest bit first; the first coded pair lands in the top bits of o_coded.
module conv_enc_core
   import conv_enc_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
)
(
   input  enc_state_t                    i_state,
   input  logic [BITS_PER_CYCLE-1:0]     i_bits,
   output enc_state_t                    o_state,
   output logic [2*BITS_PER_CYCLE-1:0]   o_coded
);

   enc_state_t                w_s;
   logic [K+1:0]              w_step;
   logic [BITS_PER_CYCLE-1:0] w_bits;

   always_comb begin
      w_s     = i_state;
      w_step  = '0;
      w_bits  = i_bits;
      o_coded = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         w_step  = enc_step(w_s, w_bits[0]);
         w_s     = w_step[K+1:2];
         w_bits  = w_bits >> 1;
         o_coded = o_coded << 2;
         o_coded[1:0] = w_step[1:0];
      end
      o_state = w_s;
   end

endmodule

// File: rtl/conv_encoder_tx.sv
// Byte-wide rate-1/2 K=3 convolutional encoder with output handshake.
// Optional tail flush (flush_i) is built only when CONV_ENC_TAIL_FLUSH_EN is defined.
module conv_encoder_tx
   import conv_enc_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dvalid_i,
   input  logic [7:0]  data_i,
   input  logic        clear_state_i,
   input  logic        ready_i,
`ifdef CONV_ENC_TAIL_FLUSH_EN
   input  logic        flush_i,
`endif
   output logic [15:0] data_o,
   output logic        valid_o,
   output logic        busy_o,
   output logic        overrun_o
);

   localparam int unsigned N        = 8 / BITS_PER_CYCLE;
   localparam logic [3:0]  LAST_CNT = 4'(N - 1);

   fsm_t                        r_state, w_next;
   enc_state_t                  r_enc, w_enc_next;
   logic [7:0]                  r_shift, w_byte;
   logic [15:0]                 r_word;
   logic [3:0]                  r_cnt;
   logic                        r_valid, r_busy, r_overrun;
   logic                        w_accept, w_clear, w_step, w_done, w_release;
   logic [2*BITS_PER_CYCLE-1:0] w_coded;

   conv_enc_core #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
      .i_state (r_enc),
      .i_bits  (r_shift[BITS_PER_CYCLE-1:0]),
      .o_state (w_enc_next),
      .o_coded (w_coded)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_byte    = data_i;
      w_clear   = 1'b0;
      w_step    = 1'b0;
      w_done    = 1'b0;
      w_release = 1'b0;
      case (r_state)
         IDLE: begin
            w_clear = clear_state_i;
            if (dvalid_i) begin
               w_accept = 1'b1;
               w_next   = ENCODE;
            end
`ifdef CONV_ENC_TAIL_FLUSH_EN
            else if (flush_i) begin
               w_accept = 1'b1;
               w_byte   = '0;
               w_next   = ENCODE;
            end
`endif
         end
         ENCODE: begin
            w_step = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_done = 1'b1;
               w_next = HOLD;
            end
         end
         HOLD: begin
            if (ready_i) begin
               w_release = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // A clear coinciding with acceptance takes effect before the first encode edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enc     <= '0;
         r_shift   <= '0;
         r_word    <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_clear) r_enc <= '0;
         if (w_accept) begin
            r_shift <= w_byte;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
         end
         if (w_step) begin
            r_enc   <= w_enc_next;
            r_shift <= r_shift >> BITS_PER_CYCLE;
            r_word  <= (r_word << (2 * BITS_PER_CYCLE)) | 16'(w_coded);
            r_cnt   <= r_cnt + 4'd1;
         end
         if (w_done) r_valid <= 1'b1;
         if (w_release) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end
         if (dvalid_i && r_busy) r_overrun <= 1'b1;
      end
   end

   assign data_o    = r_word;
   assign valid_o   = r_valid;
   assign busy_o    = r_busy;
   assign overrun_o = r_overrun;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx: expected words are queued at issue time
// and a negedge monitor compares every completed output handshake.
module tb_conv_encoder_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       dvalid = 1'b0;
   logic [7:0] data   = '0;
   logic       clr    = 1'b0;
   logic       ready  = 1'b0;
`ifdef CONV_ENC_TAIL_FLUSH_EN
   logic       flush  = 1'b0;
`endif
   logic [15:0] data_o;
   logic        valid_o, busy_o, overrun_o;

   logic        m_dvalid = 1'b0;
   logic [7:0]  m_data   = '0;
   logic        m_ready  = 1'b1;
   logic [15:0] d2_data, d8_data;
   logic        d2_valid, d2_busy, d2_ovr, d8_valid, d8_busy, d8_ovr;

   conv_encoder_tx #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .dvalid_i(dvalid), .data_i(data),
      .clear_state_i(clr), .ready_i(ready),
`ifdef CONV_ENC_TAIL_FLUSH_EN
      .flush_i(flush),
`endif
      .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
   );

   conv_encoder_tx #(.BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .dvalid_i(m_dvalid), .data_i(m_data),
      .clear_state_i(1'b0), .ready_i(m_ready),
`ifdef CONV_ENC_TAIL_FLUSH_EN
      .flush_i(1'b0),
`endif
      .data_o(d2_data), .valid_o(d2_valid), .busy_o(d2_busy), .overrun_o(d2_ovr)
   );

   conv_encoder_tx #(.BITS_PER_CYCLE(8)) dut8 (
      .clk(clk), .rst(rst), .dvalid_i(m_dvalid), .data_i(m_data),
      .clear_state_i(1'b0), .ready_i(m_ready),
`ifdef CONV_ENC_TAIL_FLUSH_EN
      .flush_i(1'b0),
`endif
      .data_o(d8_data), .valid_o(d8_valid), .busy_o(d8_busy), .overrun_o(d8_ovr)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid_o && ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", data_o);
         end else begin
            check("word", 32'(data_o), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_byte(input logic [7:0] b);
      dvalid = 1'b1;
      data   = b;
      tick(1);
      dvalid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int unsigned c = 0;
      while (busy_o && c < 100) begin
         tick(1);
         c++;
      end
      check(name, 32'(busy_o), 32'd0);
   endtask

   task automatic send(input logic [7:0] b, input logic [15:0] e);
      exp_q.push_back(e);
      pulse_byte(b);
      wait_idle("send_idle");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned bad;
      int unsigned c;

      tick(3);
      check("rst_data",    32'(data_o),    32'd0);
      check("rst_valid",   32'(valid_o),   32'd0);
      check("rst_busy",    32'(busy_o),    32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      rst = 1'b0;
      tick(1);

      // 0x35 on all three widths; latency 8 / 4 / 1 edges after acceptance.
      ready    = 1'b1;
      exp_q.push_back(16'hE217);
      dvalid   = 1'b1; data   = 8'h35;
      m_dvalid = 1'b1; m_data = 8'h35;
      tick(1);
      dvalid = 1'b0; m_dvalid = 1'b0;
      check("busy_at_accept", 32'(busy_o),   32'd1);
      check("bpc8_early",     32'(d8_valid), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         if (k == 1) begin
            check("bpc8_valid", 32'(d8_valid), 32'd1);
            check("bpc8_word",  32'(d8_data),  32'hE217);
         end
         if (k == 3) check("bpc2_early", 32'(d2_valid), 32'd0);
         if (k == 4) begin
            check("bpc2_valid", 32'(d2_valid), 32'd1);
            check("bpc2_word",  32'(d2_data),  32'hE217);
         end
         if (k == 7) check("bpc1_early", 32'(valid_o), 32'd0);
         if (k == 8) check("bpc1_valid", 32'(valid_o), 32'd1);
      end
      tick(1);
      check("busy_release", 32'(busy_o), 32'd0);

      // Memory carries across bytes; clear_state_i only in IDLE.
      send(8'hFF, 16'hDAAA);
      send(8'h00, 16'h7000);
      send(8'hFF, 16'hDAAA);
      clr = 1'b1;
      send(8'h00, 16'h0000);
      clr = 1'b0;
      send(8'hFF, 16'hDAAA);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      send(8'h00, 16'h0000);
      send(8'hFF, 16'hDAAA);
      exp_q.push_back(16'h7000);
      pulse_byte(8'h00);
      tick(2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      wait_idle("busy_clear_idle");

      // Backpressure.
      ready = 1'b0;
      exp_q.push_back(16'hE217);
      pulse_byte(8'h35);
      c = 0;
      while (!valid_o && c < 20) begin
         tick(1);
         c++;
      end
      check("stall_valid", 32'(valid_o), 32'd1);
      bad = 0;
      repeat (20) begin
         tick(1);
         if (!valid_o || !busy_o || data_o !== 16'hE217) bad++;
      end
      check("stall_stable", bad, 32'd0);
      ready = 1'b1;
      tick(1);
      check("release_busy",  32'(busy_o),  32'd0);
      check("release_valid", 32'(valid_o), 32'd0);
      exp_q.push_back(16'hDAAA);
      pulse_byte(8'hFF);
      check("accept_after_release", 32'(busy_o), 32'd1);
      wait_idle("after_release_idle");

      // Overrun: second strobe while encoding is dropped.
      check("overrun_clear", 32'(overrun_o), 32'd0);
      exp_q.push_back(16'h9217);
      pulse_byte(8'h35);
      tick(2);
      pulse_byte(8'hAA);
      check("overrun_set", 32'(overrun_o), 32'd1);
      wait_idle("overrun_idle");
      tick(5);
      check("overrun_sticky", 32'(overrun_o), 32'd1);
      check("no_extra_word",  32'(busy_o),    32'd0);

      // Asynchronous reset in the middle of ENCODE.
      pulse_byte(8'h00);
      tick(2);
      #2 rst = 1'b1;
      #2;
      check("midrst_data",    32'(data_o),    32'd0);
      check("midrst_valid",   32'(valid_o),   32'd0);
      check("midrst_busy",    32'(busy_o),    32'd0);
      check("midrst_overrun", 32'(overrun_o), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(12);
      check("midrst_no_word", 32'(valid_o), 32'd0);

`ifdef CONV_ENC_TAIL_FLUSH_EN
      send(8'hFF, 16'hDAAA);
      exp_q.push_back(16'h7000);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_idle("flush_idle");
      send(8'h00, 16'h0000);
      exp_q.push_back(16'hE217);
      flush = 1'b1;
      pulse_byte(8'h35);
      flush = 1'b0;
      wait_idle("flush_dvalid_idle");
      tick(4);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
